// File: rtl/cycle_sequencer_pkg.sv
// Shared types for the instruction-cycle sequencer: state encoding,
// phase codes seen by the 2-to-4 phase decoder and the output bundle.
package cycle_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_HALTED    = 3'd5,
        ST_ERROR     = 3'd6
    } state_t;

    typedef logic [1:0] phase_t;

    localparam phase_t PH_FETCH  = 2'b00;
    localparam phase_t PH_DECODE = 2'b01;
    localparam phase_t PH_EXEC   = 2'b10;
    localparam phase_t PH_WB     = 2'b11;

    // Decoder side: S selects one of four one-hot phase enables
    // (bit 0 fetch, bit 1 decode, bit 2 execute, bit 3 writeback).
    function automatic logic [3:0] phase_enable(phase_t s);
        return 4'b0001 << s;
    endfunction

    typedef struct packed {
        phase_t s;
        logic   phase_valid;
        logic   mem_req;
        logic   halted;
        logic   timeout_err;
    } seq_out_t;

    // Output values that hold while the sequencer sits in a given state.
    function automatic seq_out_t outputs_for(state_t st);
        seq_out_t o;
        o = '0;
        case (st)
            ST_FETCH: begin
                o.s           = PH_FETCH;
                o.phase_valid = 1'b1;
                o.mem_req     = 1'b1;
            end
            ST_DECODE: begin
                o.s           = PH_DECODE;
                o.phase_valid = 1'b1;
            end
            ST_EXECUTE: begin
                o.s           = PH_EXEC;
                o.phase_valid = 1'b1;
            end
            ST_WRITEBACK: begin
                o.s           = PH_WB;
                o.phase_valid = 1'b1;
            end
            ST_HALTED: o.halted      = 1'b1;
            ST_ERROR:  o.timeout_err = 1'b1;
            default:   o = '0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/cycle_sequencer_if.sv
// Control/status bundle between the sequencer and its environment.
interface cycle_sequencer_if
    import cycle_sequencer_pkg::*;
#(
    parameter int PC_WIDTH = 8
);
    logic                run;
    logic                step;
    logic                halt_req;
    logic                mem_ready;
    logic                instr_is_halt;
    logic                pc_load;
    logic [PC_WIDTH-1:0] pc_target;
    phase_t              S;
    logic                phase_valid;
    logic                mem_req;
    logic [PC_WIDTH-1:0] pc;
    logic                busy;
    logic                halted;
    logic                timeout_err;
    logic [15:0]         instr_count;

    modport master (
        output run, step, halt_req, mem_ready, instr_is_halt, pc_load, pc_target,
        input  S, phase_valid, mem_req, pc, busy, halted, timeout_err, instr_count
    );

    modport slave (
        input  run, step, halt_req, mem_ready, instr_is_halt, pc_load, pc_target,
        output S, phase_valid, mem_req, pc, busy, halted, timeout_err, instr_count
    );
endinterface

// File: rtl/cycle_sequencer_fetch_wait_timer.sv
// Counts consecutive FETCH cycles without mem_ready. at_limit flags that the
// current increment brings the count to TIMEOUT.
module fetch_wait_timer #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic at_limit
);
    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

    logic [7:0] count;

    // Wait counter: clear has priority over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 8'd1;
        end
    end

    assign at_limit = en && (count == LAST);
endmodule

// File: rtl/cycle_sequencer.sv
// Instruction-cycle controller: steps fetch/decode/execute/writeback,
// handshakes instruction memory, owns the PC and retired-instruction count.
module cycle_sequencer
    import cycle_sequencer_pkg::*;
#(
    parameter int          PC_WIDTH = 8,
    parameter int unsigned TIMEOUT  = 15
) (
    input logic clk,
    input logic rst_n,
    cycle_sequencer_if.slave bus
);
    state_t              state;
    seq_out_t            outs;
    logic [PC_WIDTH-1:0] pc_r;
    logic [15:0]         count_r;
    logic                halt_pend;
    logic                run_q;
    logic                in_fetch;
    logic                wait_limit;
    logic                active;

    assign in_fetch = (state == ST_FETCH);
    assign active   = (state == ST_FETCH) || (state == ST_DECODE) ||
                      (state == ST_EXECUTE) || (state == ST_WRITEBACK);

    fetch_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (!in_fetch || bus.mem_ready),
        .en       (in_fetch && !bus.mem_ready),
        .at_limit (wait_limit)
    );

    // Sequencer FSM; outputs are registered alongside the state they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            outs      <= '0;
            pc_r      <= '0;
            count_r   <= '0;
            halt_pend <= 1'b0;
            run_q     <= 1'b0;
        end else begin
            run_q <= bus.run;
            if (active && bus.halt_req) begin
                halt_pend <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    halt_pend <= 1'b0;
                    if (bus.run && !run_q) begin
                        state <= ST_FETCH;
                        outs  <= outputs_for(ST_FETCH);
                    end
                end
                ST_FETCH: begin
                    if (bus.mem_ready) begin
                        state <= ST_DECODE;
                        outs  <= outputs_for(ST_DECODE);
                    end else if (wait_limit) begin
                        state <= ST_ERROR;
                        outs  <= outputs_for(ST_ERROR);
                    end
                end
                ST_DECODE: begin
                    if (bus.instr_is_halt) begin
                        state <= ST_HALTED;
                        outs  <= outputs_for(ST_HALTED);
                    end else begin
                        state <= ST_EXECUTE;
                        outs  <= outputs_for(ST_EXECUTE);
                    end
                end
                ST_EXECUTE: begin
                    state <= ST_WRITEBACK;
                    outs  <= outputs_for(ST_WRITEBACK);
                end
                ST_WRITEBACK: begin
                    pc_r <= bus.pc_load ? bus.pc_target : pc_r + PC_WIDTH'(1);
                    if (count_r != 16'hFFFF) begin
                        count_r <= count_r + 16'd1;
                    end
                    if (bus.step || halt_pend || bus.halt_req) begin
                        state     <= ST_IDLE;
                        outs      <= outputs_for(ST_IDLE);
                        halt_pend <= 1'b0;
                    end else begin
                        state <= ST_FETCH;
                        outs  <= outputs_for(ST_FETCH);
                    end
                end
                ST_HALTED, ST_ERROR: begin
                    state <= state;
                end
                default: begin
                    state <= ST_IDLE;
                    outs  <= outputs_for(ST_IDLE);
                end
            endcase
        end
    end

    assign bus.S           = outs.s;
    assign bus.phase_valid = outs.phase_valid;
    assign bus.busy        = outs.phase_valid;
    assign bus.mem_req     = outs.mem_req;
    assign bus.halted      = outs.halted;
    assign bus.timeout_err = outs.timeout_err;
    assign bus.pc          = pc_r;
    assign bus.instr_count = count_r;
endmodule

// File: tb/tb_cycle_sequencer.sv
// Bench for cycle_sequencer: directed scenarios plus random traffic, checked
// every cycle against an instruction-level reference model.
module tb_cycle_sequencer;
    localparam int TIMEOUT = 15;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    cycle_sequencer_if #(.PC_WIDTH(8)) bus ();

    cycle_sequencer #(.PC_WIDTH(8), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model. Phase: -1 idle, 0..3 fetch/decode/execute/writeback,
    // 4 halted, 5 error.
    int m_ph;
    int m_wait;
    int m_pc;
    int m_cnt;
    bit m_hpend;
    bit m_prev_run;

    function automatic void model_reset();
        m_ph       = -1;
        m_wait     = 0;
        m_pc       = 0;
        m_cnt      = 0;
        m_hpend    = 1'b0;
        m_prev_run = 1'b0;
    endfunction

    function automatic void model_step();
        bit rise;
        if (!rst_n) begin
            model_reset();
            return;
        end
        rise       = bus.run && !m_prev_run;
        m_prev_run = bus.run;
        if (m_ph >= 0 && m_ph <= 3 && bus.halt_req) m_hpend = 1'b1;
        case (m_ph)
            -1: begin
                m_hpend = 1'b0;
                if (rise) m_ph = 0;
            end
            0: begin
                if (bus.mem_ready) begin
                    m_wait = 0;
                    m_ph   = 1;
                end else begin
                    m_wait = m_wait + 1;
                    if (m_wait >= TIMEOUT) m_ph = 5;
                end
            end
            1: m_ph = bus.instr_is_halt ? 4 : 2;
            2: m_ph = 3;
            3: begin
                m_pc  = bus.pc_load ? int'(bus.pc_target) : (m_pc + 1) % 256;
                m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
                if (bus.step || m_hpend) begin
                    m_ph    = -1;
                    m_hpend = 1'b0;
                end else begin
                    m_ph = 0;
                end
            end
            default: ;
        endcase
    endfunction

    function automatic void chk(string nm, longint act, longint exp);
        total = total + 1;
        if (act != exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            #1;
            model_step();
        end
    end

    // Per-cycle comparison of every output against the model.
    initial begin
        forever begin
            @(negedge clk);
            begin
                bit act_ph;
                act_ph = (m_ph >= 0 && m_ph <= 3);
                chk("S",           bus.S,           act_ph ? longint'(m_ph) : 0);
                chk("phase_valid", bus.phase_valid, act_ph ? 1 : 0);
                chk("busy",        bus.busy,        act_ph ? 1 : 0);
                chk("mem_req",     bus.mem_req,     (m_ph == 0) ? 1 : 0);
                chk("halted",      bus.halted,      (m_ph == 4) ? 1 : 0);
                chk("timeout_err", bus.timeout_err, (m_ph == 5) ? 1 : 0);
                chk("pc",          bus.pc,          m_pc);
                chk("instr_count", bus.instr_count, m_cnt);
            end
        end
    end

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic one_instr(input logic ld, input logic [7:0] tgt);
        bus.run = 1'b1;
        @(negedge clk);
        bus.run       = 1'b0;
        bus.pc_load   = ld;
        bus.pc_target = tgt;
        repeat (4) @(negedge clk);
        bus.pc_load = 1'b0;
    endtask

    initial begin
        int stuck;
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        model_reset();
        bus.run = 1'b0;  bus.step = 1'b0; bus.halt_req = 1'b0; bus.mem_ready = 1'b0;
        bus.instr_is_halt = 1'b0; bus.pc_load = 1'b0; bus.pc_target = '0;
        @(negedge clk);
        chk("rst_pv", bus.phase_valid, 0);
        chk("rst_pc", bus.pc, 0);
        chk("rst_cnt", bus.instr_count, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // single step
        bus.step = 1'b1; bus.mem_ready = 1'b1; bus.run = 1'b1;
        @(negedge clk);
        chk("t1_S_fetch", bus.S, 0);
        chk("t1_pv", bus.phase_valid, 1);
        bus.run = 1'b0;
        @(negedge clk); chk("t1_S_decode", bus.S, 1);
        @(negedge clk); chk("t1_S_exec", bus.S, 2);
        @(negedge clk); chk("t1_S_wb", bus.S, 3); chk("t1_pc_wb", bus.pc, 0);
        @(negedge clk);
        chk("t1_idle_pv", bus.phase_valid, 0);
        chk("t1_pc", bus.pc, 1);
        chk("t1_cnt", bus.instr_count, 1);
        chk("t1_model_pc", m_pc, 1);

        // free run, halt_req in third EXECUTE
        do_reset();
        bus.step = 1'b0; bus.run = 1'b1;
        @(negedge clk);
        chk("t2_S_f1", bus.S, 0);
        bus.run = 1'b0;
        repeat (10) @(negedge clk);
        chk("t2_S_e3", bus.S, 2);
        bus.halt_req = 1'b1;
        @(negedge clk);
        chk("t2_S_w3", bus.S, 3);
        bus.halt_req = 1'b0;
        @(negedge clk);
        chk("t2_pv", bus.phase_valid, 0);
        chk("t2_pc", bus.pc, 3);
        chk("t2_cnt", bus.instr_count, 3);
        chk("t2_model_cnt", m_cnt, 3);

        // fetch stalled three cycles
        bus.step = 1'b1; bus.mem_ready = 1'b0; bus.run = 1'b1;
        @(negedge clk);
        bus.run = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t3_S_fetch", bus.S, 0);
            chk("t3_mem_req", bus.mem_req, 1);
            if (i == 3) bus.mem_ready = 1'b1;
            @(negedge clk);
        end
        chk("t3_S_decode", bus.S, 1);
        chk("t3_terr", bus.timeout_err, 0);
        repeat (3) @(negedge clk);
        chk("t3_pc", bus.pc, 4);

        // fetch timeout
        bus.mem_ready = 1'b0; bus.run = 1'b1;
        @(negedge clk);
        bus.run = 1'b0;
        for (int i = 0; i < TIMEOUT; i++) begin
            chk("t4_mem_req", bus.mem_req, 1);
            chk("t4_terr_early", bus.timeout_err, 0);
            @(negedge clk);
        end
        chk("t4_terr", bus.timeout_err, 1);
        chk("t4_mem_req_off", bus.mem_req, 0);
        chk("t4_pv", bus.phase_valid, 0);
        bus.run = 1'b1;
        @(negedge clk);
        bus.run = 1'b0;
        repeat (3) @(negedge clk);
        chk("t4_terr_sticky", bus.timeout_err, 1);
        do_reset();
        chk("t4_terr_cleared", bus.timeout_err, 0);

        // branch target and wrap
        bus.mem_ready = 1'b1; bus.step = 1'b1;
        one_instr(1'b1, 8'hA5); chk("t5_pc_load", bus.pc, 8'hA5);
        one_instr(1'b1, 8'hFF); chk("t5_pc_ff", bus.pc, 8'hFF);
        one_instr(1'b0, 8'h12); chk("t5_pc_wrap", bus.pc, 8'h00);
        chk("t5_cnt", bus.instr_count, 3);

        // HALT instruction
        bus.run = 1'b1;
        @(negedge clk);
        bus.run = 1'b0; bus.instr_is_halt = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.instr_is_halt = 1'b0;
        chk("t6_halted", bus.halted, 1);
        chk("t6_pv", bus.phase_valid, 0);
        chk("t6_cnt", bus.instr_count, 3);
        chk("t6_pc", bus.pc, 0);
        bus.run = 1'b1;
        @(negedge clk);
        bus.run = 1'b0;
        @(negedge clk);
        chk("t6_halted_sticky", bus.halted, 1);

        // reset mid-DECODE
        do_reset();
        one_instr(1'b1, 8'h5A);
        bus.run = 1'b1;
        @(negedge clk);
        bus.run = 1'b0;
        @(negedge clk);
        chk("t7_S_decode", bus.S, 1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("t7_S", bus.S, 0);
        chk("t7_pv", bus.phase_valid, 0);
        chk("t7_pc", bus.pc, 0);
        chk("t7_cnt", bus.instr_count, 0);
        chk("t7_mem_req", bus.mem_req, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // random traffic
        stuck = 0;
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            bus.run           = ($urandom_range(0, 3) == 0);
            bus.step          = ($urandom_range(0, 3) == 0);
            bus.halt_req      = ($urandom_range(0, 15) == 0);
            bus.mem_ready     = ($urandom_range(0, 3) != 0);
            bus.instr_is_halt = ($urandom_range(0, 40) == 0);
            bus.pc_load       = ($urandom_range(0, 2) == 0);
            bus.pc_target     = 8'($urandom);
            if (m_ph >= 4) stuck = stuck + 1;
            if (stuck > 8 || $urandom_range(0, 499) == 0) begin
                stuck = 0;
                #2;
                rst_n = 1'b0;
                model_reset();
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
